// File: rtl/frame_buffer_arbiter_if.sv
// Signal bundle between the frame-buffer arbiter and its environment: video timing, draw client,
// clear control, BRAM port and scan-out pixel. The arbiter is the slave; the environment is the master.
interface frame_buffer_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 16,
    parameter int X_W        = 9,
    parameter int Y_W        = 8
);
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic                  ad_in;
    logic                  wr_valid_in;
    logic                  wr_ready_out;
    logic [X_W-1:0]        wr_x_in;
    logic [Y_W-1:0]        wr_y_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic                  clear_req_in;
    logic                  clear_busy_out;
    logic                  clear_done_out;
    logic [15:0]           drop_count_out;
    logic                  mem_en_out;
    logic                  mem_we_out;
    logic [ADDR_W-1:0]     mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_din_out;
    logic [DATA_WIDTH-1:0] mem_dout_in;
    logic [DATA_WIDTH-1:0] pixel_out;
    logic                  pixel_valid_out;

    modport slave (
        input  hcount_in, vcount_in, ad_in,
        input  wr_valid_in, wr_x_in, wr_y_in, wr_data_in, clear_req_in, mem_dout_in,
        output wr_ready_out, clear_busy_out, clear_done_out, drop_count_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_din_out, pixel_out, pixel_valid_out
    );

    modport master (
        output hcount_in, vcount_in, ad_in,
        output wr_valid_in, wr_x_in, wr_y_in, wr_data_in, clear_req_in, mem_dout_in,
        input  wr_ready_out, clear_busy_out, clear_done_out, drop_count_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_din_out, pixel_out, pixel_valid_out
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port frame-buffer BRAM: display reads own every SCALE-th active cycle,
// the clear engine and then the draw client take whatever cycles remain.
module frame_buffer_arbiter #(
    parameter int                    ACTIVE_H_PIXELS = 1280,
    parameter int                    ACTIVE_LINES    = 720,
    parameter int                    SCALE           = 4,
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    MEM_LATENCY     = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_n_in,
    frame_buffer_arbiter_if.slave fb
);
    localparam int FB_W     = ACTIVE_H_PIXELS / SCALE;
    localparam int FB_H     = ACTIVE_LINES / SCALE;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = $clog2(FB_DEPTH);
    localparam int SHIFT    = $clog2(SCALE);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       clr_addr_q;
    logic [15:0]             drop_cnt_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_din_q;
    logic [MEM_LATENCY:0]    slot_pipe_q;
    logic [MEM_LATENCY:0]    ad_pipe_q;
    logic [DATA_WIDTH-1:0]   pixel_q;
    logic                    pixel_valid_q;

    logic                    disp_slot;
    logic                    wr_ready;
    logic                    draw_acc;
    logic                    draw_in_range;
    logic [ADDR_W-1:0]       disp_addr;
    logic [ADDR_W-1:0]       draw_addr;

    assign disp_slot     = fb.ad_in && (fb.hcount_in[SHIFT-1:0] == '0);
    assign disp_addr     = ADDR_W'(32'(fb.vcount_in >> SHIFT) * FB_W + 32'(fb.hcount_in >> SHIFT));
    assign draw_addr     = ADDR_W'(32'(fb.wr_y_in) * FB_W + 32'(fb.wr_x_in));
    assign draw_in_range = (32'(fb.wr_x_in) < FB_W) && (32'(fb.wr_y_in) < FB_H);
    // Gated by reset so every output reads 0 while rst_n_in is low.
    assign wr_ready      = rst_n_in && !disp_slot && (state_q == IDLE);
    assign draw_acc      = fb.wr_valid_in && wr_ready;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            drop_cnt_q <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (disp_slot) begin
                mem_en_q   <= 1'b1;
                mem_addr_q <= disp_addr;
            end
            case (state_q)
                IDLE: begin
                    if (draw_acc) begin
                        if (draw_in_range) begin
                            mem_en_q   <= 1'b1;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= draw_addr;
                            mem_din_q  <= fb.wr_data_in;
                        end else if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                    end
                    if (fb.clear_req_in) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                    end
                end
                CLEAR: begin
                    // Display slots simply pause the sweep; the address only advances on a write.
                    if (!disp_slot) begin
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= clr_addr_q;
                        mem_din_q  <= CLEAR_VALUE;
                        if (clr_addr_q == ADDR_W'(FB_DEPTH - 1)) begin
                            state_q <= DONE;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan-out: one cycle to register the address, MEM_LATENCY in the BRAM, one into pixel_q.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            slot_pipe_q   <= '0;
            ad_pipe_q     <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            slot_pipe_q   <= (slot_pipe_q << 1) | (MEM_LATENCY + 1)'(disp_slot);
            ad_pipe_q     <= (ad_pipe_q << 1) | (MEM_LATENCY + 1)'(fb.ad_in);
            pixel_valid_q <= ad_pipe_q[MEM_LATENCY];
            if (!ad_pipe_q[MEM_LATENCY]) begin
                pixel_q <= '0;
            end else if (slot_pipe_q[MEM_LATENCY]) begin
                pixel_q <= fb.mem_dout_in;
            end
        end
    end

    assign fb.wr_ready_out    = wr_ready;
    assign fb.clear_busy_out  = (state_q == CLEAR);
    assign fb.clear_done_out  = (state_q == DONE);
    assign fb.drop_count_out  = drop_cnt_q;
    assign fb.mem_en_out      = mem_en_q;
    assign fb.mem_we_out      = mem_we_q;
    assign fb.mem_addr_out    = mem_addr_q;
    assign fb.mem_din_out     = mem_din_q;
    assign fb.pixel_out       = pixel_q;
    assign fb.pixel_valid_out = pixel_valid_q;
endmodule
